softmax_downscale_stream: RTL and testbench
===========================================

Name: softmax_downscale_stream

Overview:
- Parametrised successor of the softmax front end: accepts a vector of signed fixed-point scores of runtime-selectable length.
- Buffers the vector and tracks its maximum, then streams out (x - max) for every element.
- Adds valid/ready handshakes on both sides, a last-element flag and length error reporting.
- Sits between the score source and the exp stage; its output stream feeds exp directly.

Parameters:
- DATA_W, 32, width of signed two's-complement input and output samples.
- MAX_LEN, 16, buffer depth and maximum vector length; must be at least 1.
- LEN_W, derived localparam clog2(MAX_LEN+1), width of the length and counter fields.

Ports:
- clock_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle pulse that begins a vector; sampled only in IDLE.
- len_i  in  LEN_W  vector length, sampled together with start_i.
- in_data_i  in  DATA_W  signed input score.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  high in LOAD only.
- out_data_o  out  DATA_W  signed result: x[i] - max, saturated.
- out_valid_o  out  1  output beat valid.
- out_last_o  out  1  high together with out_valid_o on element len-1.
- out_ready_i  in  1  downstream accept.
- max_o  out  DATA_W  maximum of the most recently loaded vector.
- busy_o  out  1  high when state is not IDLE.
- err_len_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: asynchronous, active-high. Forces state to IDLE and clears every output register to 0 (out_data_o, out_valid_o, out_last_o, max_o, err_len_o). Buffer contents are don't-care. Reset asserted mid-LOAD or mid-DRAIN aborts the vector with no further output beats.
- States: IDLE, LOAD, DRAIN.
- IDLE + start_i, len_i in 1..MAX_LEN: latch len, set the write counter to 0, set running max to the most-negative value, go to LOAD.
- IDLE + start_i, len_i = 0 or len_i > MAX_LEN: err_len_o = 1 for exactly one cycle; remain in IDLE.
- start_i is ignored in LOAD and DRAIN. It raises no error.
- LOAD:
  - in_ready_o = 1. A beat is accepted when in_valid_i && in_ready_o.
  - On each accepted beat: write buf[wr] = in_data_i, running max = max(running max, in_data_i) as a signed compare, wr++.
  - The edge that accepts beat len-1 moves to DRAIN, sets rd = 0 and registers max_o with the final max, including that last beat.
- DRAIN:
  - in_ready_o = 0.
  - The output register loads when !out_valid_o || out_ready_i. Load values: out_data_o = sat(buf[rd] - max_o), out_valid_o = 1, out_last_o = (rd == len-1), then rd++.
  - When the last beat handshakes (out_valid_o && out_ready_i && out_last_o): clear out_valid_o and out_last_o, return to IDLE.
  - out_data_o, out_valid_o and out_last_o are held stable while out_valid_o && !out_ready_i.
- Latency and throughput:
  - The last input beat is accepted at edge N.
  - The first out_valid_o rises after edge N+1.
  - With out_ready_i held high, throughput is one element per cycle.
  - A new start_i is accepted no earlier than the cycle after the final output handshake.
- Arithmetic: the difference is computed at DATA_W+1 bits. If the result is below -2^(DATA_W-1), out_data_o is clamped to -2^(DATA_W-1). The result is never positive.
- max_o: holds its value from DRAIN entry until the next accepted start; it is not cleared on the return to IDLE.
- busy_o: combinational from state.

Decomposition:
- Shared package softmax_pkg holds:
  - the default data width;
  - the signed saturation min/max constants;
  - the state enum encoding for IDLE/LOAD/DRAIN.
- One sub-module, softmax_vec_buffer: MAX_LEN x DATA_W storage with one synchronous write port and one asynchronous read port. Read data feeds the output subtract/saturate register.
- FSM, counters, max tracking and saturation stay in the top module.

Test Plan:
- Basic vector: len=4, inputs {3,-1,7,2}, out_ready_i=1 -> out_data_o {-4,-8,0,-5}; out_last_o only on -5; max_o=7; busy_o falls after the last handshake.
- Backpressure: same vector, out_ready_i low for 3 cycles on the 2nd element -> -8 held stable with out_valid_o=1; no loss or duplication; order preserved.
- Length errors: start_i with len_i=0, then len_i=MAX_LEN+1 -> one-cycle err_len_o each time; busy_o stays 0; in_ready_o stays 0.
- Saturation plus full depth: len=MAX_LEN, first element -2^31, rest 2^31-1 -> first output -2^31 (clamped), all others 0, out_last_o on element 15.
- Single element plus input gaps: len=1, in_valid_i low 2 cycles then value -5 -> one beat out_data_o=0 with out_last_o=1; max_o=-5.
- Reset mid-DRAIN: assert reset_i after 2 of 4 outputs -> all outputs 0 immediately, state IDLE; a following len=2 vector {1,1} yields {0,0}.

Source files
------------

// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared widths, saturation limits and FSM encoding for the softmax downscale stream
package softmax_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};
    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/softmax_vec_buffer.sv
// rtl/softmax_vec_buffer.sv - vector storage, one synchronous write port and one asynchronous read port
module softmax_vec_buffer
    import softmax_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clock_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    // No reset: contents are only read after being written for the current vector.
    logic [DATA_W-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/softmax_downscale_stream.sv
// rtl/softmax_downscale_stream.sv - buffers a score vector, tracks its maximum, then streams sat(x - max)
module softmax_downscale_stream
    import softmax_pkg::*;
#(
    parameter int  DATA_W  = DATA_W_DEF,
    parameter int  MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] max_o,
    output logic              busy_o,
    output logic              err_len_o
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
    localparam logic signed [DATA_W-1:0] MIN_V =
        (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MIN) : {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_V =
        (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MAX) : {1'b0, {(DATA_W-1){1'b1}}};

    state_e state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         wr_q, wr_d;
    logic [LEN_W-1:0]         rd_q, rd_d;
    logic signed [DATA_W-1:0] run_max_q, run_max_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     err_len_q, err_len_d;

    logic                     accept;
    logic signed [DATA_W-1:0] new_max;
    logic [DATA_W-1:0]        buf_rd_data;
    logic [DATA_W:0]          diff;
    logic [DATA_W-1:0]        sat_val;

    softmax_vec_buffer #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (IDX_W)
    ) u_buf (
        .clock_i   (clock_i),
        .wr_en_i   (accept),
        .wr_addr_i (wr_q[IDX_W-1:0]),
        .wr_data_i (in_data_i),
        .rd_addr_i (rd_q[IDX_W-1:0]),
        .rd_data_o (buf_rd_data)
    );

    assign accept  = (state_q == ST_LOAD) && in_valid_i;
    assign new_max = ($signed(in_data_i) > run_max_q) ? $signed(in_data_i) : run_max_q;

    // One extra bit keeps the subtraction exact; the high clamp only guards non-default use.
    assign diff = {buf_rd_data[DATA_W-1], buf_rd_data} - {max_q[DATA_W-1], max_q};

    always_comb begin
        sat_val = diff[DATA_W-1:0];
        if (diff[DATA_W] && !diff[DATA_W-1]) begin
            sat_val = MIN_V;
        end else if (!diff[DATA_W] && diff[DATA_W-1]) begin
            sat_val = MAX_V;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        run_max_d   = run_max_q;
        max_d       = max_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_len_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if ((len_i != '0) && (len_i <= MAX_LEN_L)) begin
                        len_d     = len_i;
                        wr_d      = '0;
                        run_max_d = MIN_V;
                        state_d   = ST_LOAD;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    run_max_d = new_max;
                    wr_d      = wr_q + ONE_L;
                    if (wr_q == len_q - ONE_L) begin
                        max_d   = new_max;
                        rd_d    = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready_i && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else if (!out_valid_q || out_ready_i) begin
                    out_data_d  = sat_val;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_q == len_q - ONE_L);
                    rd_d        = rd_q + ONE_L;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            run_max_q   <= '0;
            max_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            run_max_q   <= run_max_d;
            max_q       <= max_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_len_q   <= err_len_d;
        end
    end

    assign in_ready_o  = (state_q == ST_LOAD);
    assign busy_o      = (state_q != ST_IDLE);
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign max_o       = max_q;
    assign err_len_o   = err_len_q;

endmodule

// File: tb/tb_softmax_downscale_stream.sv
// tb/tb_softmax_downscale_stream.sv - scoreboard bench for the softmax downscale stream
module tb_softmax_downscale_stream;

    localparam int DW = 32;
    localparam int ML = 16;
    localparam int LW = $clog2(ML + 1);

    logic          clock_i     = 1'b0;
    logic          reset_i     = 1'b1;
    logic          start_i     = 1'b0;
    logic [LW-1:0] len_i       = '0;
    logic [DW-1:0] in_data_i   = '0;
    logic          in_valid_i  = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_last_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] max_o;
    logic          busy_o;
    logic          err_len_o;

    softmax_downscale_stream #(
        .DATA_W  (DW),
        .MAX_LEN (ML)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .max_o       (max_o),
        .busy_o      (busy_o),
        .err_len_o   (err_len_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 exp_e;
    logic signed [DW-1:0] vec[$];
    int                   n_chk      = 0;
    int                   n_pass     = 0;
    int                   hs_cnt     = 0;
    int                   stall_hs   = -1;
    int                   stall_left = 0;
    logic                 held       = 1'b0;
    logic [DW-1:0]        held_data  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    always @(negedge clock_i) begin
        if (reset_i) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(out_valid_o), 64'd1);
                chk("hold_data", 64'(out_data_o), 64'(held_data));
            end
            if (out_valid_o && out_ready_i) begin
                hs_cnt++;
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    chk("out_data", 64'(out_data_o), 64'(exp_e.data));
                    chk("out_last", 64'(out_last_o), 64'(exp_e.last));
                end
            end
            held      = out_valid_o && !out_ready_i;
            held_data = out_data_o;
        end
    end

    always @(posedge clock_i) begin
        #1;
        if (stall_left > 0 && hs_cnt == stall_hs) begin
            out_ready_i = 1'b0;
            stall_left--;
        end else begin
            out_ready_i = 1'b1;
        end
    end

    task automatic send_vec(input int gap);
        int     n;
        longint mx;
        longint d;
        n  = vec.size();
        mx = -64'sd2147483648;
        for (int i = 0; i < n; i++) if (longint'(vec[i]) > mx) mx = longint'(vec[i]);
        for (int i = 0; i < n; i++) begin
            d = longint'(vec[i]) - mx;
            if (d < -64'sd2147483648) d = -64'sd2147483648;
            exp_q.push_back('{data: d[DW-1:0], last: (i == n - 1)});
        end
        start_i = 1'b1;
        len_i   = LW'(n);
        @(posedge clock_i); #1;
        start_i = 1'b0;
        chk("busy_load", 64'(busy_o), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid_i = 1'b0;
                    @(posedge clock_i); #1;
                end
            end
            in_valid_i = 1'b1;
            in_data_i  = vec[i];
            chk("in_ready", 64'(in_ready_o), 64'd1);
            @(posedge clock_i); #1;
        end
        in_valid_i = 1'b0;
        chk("max_o", 64'(max_o), 64'(mx[DW-1:0]));
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while ((busy_o || exp_q.size() != 0) && cyc < 500) begin
            @(posedge clock_i); #1;
            cyc++;
        end
        chk("drain_timeout", 64'(cyc < 500), 64'd1);
        chk("busy_idle", 64'(busy_o), 64'd0);
        chk("valid_idle", 64'(out_valid_o), 64'd0);
        chk("last_idle", 64'(out_last_o), 64'd0);
    endtask

    task automatic len_err(input int l);
        start_i = 1'b1;
        len_i   = LW'(l);
        @(posedge clock_i); #1;
        start_i = 1'b0;
        chk("err_pulse", 64'(err_len_o), 64'd1);
        chk("err_busy", 64'(busy_o), 64'd0);
        chk("err_in_ready", 64'(in_ready_o), 64'd0);
        @(posedge clock_i); #1;
        chk("err_clear", 64'(err_len_o), 64'd0);
        chk("err_busy2", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int base;
        int cyc;
        repeat (2) @(posedge clock_i);
        #1;
        chk("rst_data", 64'(out_data_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_last", 64'(out_last_o), 64'd0);
        chk("rst_max", 64'(max_o), 64'd0);
        chk("rst_err", 64'(err_len_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);
        reset_i = 1'b0;
        @(posedge clock_i); #1;

        vec = '{3, -1, 7, 2};
        send_vec(0);
        wait_done();

        stall_hs   = hs_cnt + 1;
        stall_left = 3;
        vec = '{3, -1, 7, 2};
        send_vec(0);
        wait_done();
        chk("stall_applied", 64'(stall_left), 64'd0);

        len_err(0);
        len_err(ML + 1);

        vec.delete();
        vec.push_back(32'sh8000_0000);
        for (int i = 1; i < ML; i++) vec.push_back(32'sh7fff_ffff);
        send_vec(0);
        wait_done();

        vec = '{-5};
        send_vec(2);
        wait_done();

        base = hs_cnt;
        vec = '{5, -3, 9, 1};
        send_vec(0);
        cyc = 0;
        while (hs_cnt < base + 2 && cyc < 100) begin
            @(posedge clock_i); #1;
            cyc++;
        end
        chk("mid_drain_timeout", 64'(cyc < 100), 64'd1);
        reset_i = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_data", 64'(out_data_o), 64'd0);
        chk("arst_valid", 64'(out_valid_o), 64'd0);
        chk("arst_last", 64'(out_last_o), 64'd0);
        chk("arst_max", 64'(max_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_i); #1;
            chk("post_rst_quiet", 64'(out_valid_o), 64'd0);
        end

        vec = '{1, 1};
        send_vec(0);
        wait_done();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
